hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage RISC-V core. It watches the instruction in decode and the instruction in execute. It drives the stall and flush controls of the PC, IF/ID and ID/EX registers (the ID/EX register takes `flush_in` directly). It resolves three cases:
- load-use hazards, with a one-bubble insert;
- taken branches and jumps, with a multi-cycle wrong-path squash;
- multi-cycle execute operations (mul/div), with a hold and a watchdog.

---
 rtl/hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the five-stage RISC-V core.
// It resolves load-use hazards, taken-branch wrong-path squashes and
// multi-cycle execute holds by driving the PC, IF/ID and ID/EX stall and flush
// controls.
// Optional feature macro: HAZARD_CTRL_PERF_EN enables the saturating stall and
// flush performance counters. When it is undefined, both counter ports read 0.
module hazard_ctrl #(
   parameter int INDEX        = 5,
   parameter int REDIRECT_CYC = 1,
   parameter int MC_MAX_CYC   = 64,
   parameter int CNT_W        = 32
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [INDEX-1:0] id_rs1_in,
   input  logic [INDEX-1:0] id_rs2_in,
   input  logic             id_use_rs1_in,
   input  logic             id_use_rs2_in,
   input  logic [INDEX-1:0] ex_rd_in,
   input  logic             ex_mem_read_in,
   input  logic             ex_branch_taken_in,
   input  logic             ex_mc_start_in,
   input  logic             ex_mc_done_in,
   output logic             pc_stall_out,
   output logic             ifid_stall_out,
   output logic             ifid_flush_out,
   output logic             idex_stall_out,
   output logic             idex_flush_out,
   output logic [1:0]       state_out,
   output logic             mc_timeout_out,
   output logic [CNT_W-1:0] stall_cnt_out,
   output logic [CNT_W-1:0] flush_cnt_out
);

   localparam logic [1:0] ST_RUN        = 2'd0;
   localparam logic [1:0] ST_LOAD_STALL = 2'd1;
   localparam logic [1:0] ST_MC_WAIT    = 2'd2;
   localparam logic [1:0] ST_REDIRECT   = 2'd3;

   localparam logic [2:0] REDIR_INIT = 3'(REDIRECT_CYC);
   localparam logic [7:0] WDOG_MAX   = 8'(MC_MAX_CYC);

   logic [1:0] state_reg, state_next;
   logic [2:0] rcnt_reg, rcnt_next;
   logic [7:0] wdog_reg, wdog_next;
   logic       tmo_reg, tmo_next;

   // Raw requests before conflict resolution and reset gating
   logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
   logic lu_haz;

   // Load-use: a load in execute writes a register the decode instruction reads
   always_comb begin
      lu_haz = ex_mem_read_in && (ex_rd_in != '0) &&
               ((id_use_rs1_in && (id_rs1_in == ex_rd_in)) ||
                (id_use_rs2_in && (id_rs2_in == ex_rd_in)));
   end

   // Next-state and control decode; RUN, LOAD_STALL and REDIRECT share the event rules
   always_comb begin
      state_next = state_reg;
      rcnt_next  = rcnt_reg;
      wdog_next  = wdog_reg;
      tmo_next   = tmo_reg;
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_stall = 1'b0;
      idex_flush = 1'b0;
      case (state_reg)
         ST_MC_WAIT: begin
            if (ex_mc_done_in) begin
               state_next = ST_RUN;
            end else if (wdog_reg >= WDOG_MAX) begin
               // Unit never answered: release the pipe and flag it permanently
               tmo_next   = 1'b1;
               state_next = ST_RUN;
            end else begin
               pc_stall   = 1'b1;
               ifid_stall = 1'b1;
               idex_stall = 1'b1;
               wdog_next  = wdog_reg + 8'd1;
            end
         end
         default: begin
            // Baseline with no event: REDIRECT keeps squashing until the count runs out
            if (state_reg == ST_REDIRECT) begin
               ifid_flush = 1'b1;
               if (rcnt_reg <= 3'd1) begin
                  state_next = ST_RUN;
               end else begin
                  rcnt_next  = rcnt_reg - 3'd1;
                  state_next = ST_REDIRECT;
               end
            end else begin
               state_next = ST_RUN;
            end

            if (ex_branch_taken_in) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               rcnt_next  = REDIR_INIT;
               state_next = ST_REDIRECT;
            end else if (ex_mc_start_in) begin
               // A result arriving in the same cycle needs no hold at all
               if (!ex_mc_done_in) begin
                  pc_stall   = 1'b1;
                  ifid_stall = 1'b1;
                  idex_stall = 1'b1;
                  wdog_next  = 8'd0;
                  state_next = ST_MC_WAIT;
               end
            end else if (lu_haz) begin
               pc_stall   = 1'b1;
               ifid_stall = 1'b1;
               idex_flush = 1'b1;
               state_next = ST_LOAD_STALL;
            end
         end
      endcase
   end

   // Flush dominates stall per register; reset forces every control low
   always_comb begin
      pc_stall_out   = pc_stall & rst_in;
      ifid_flush_out = ifid_flush & rst_in;
      ifid_stall_out = ifid_stall & ~ifid_flush & rst_in;
      idex_flush_out = idex_flush & rst_in;
      idex_stall_out = idex_stall & ~idex_flush & rst_in;
      state_out      = state_reg;
      mc_timeout_out = tmo_reg;
   end

   // FSM, redirect counter, watchdog and sticky timeout flag
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_reg <= ST_RUN;
         rcnt_reg  <= 3'd0;
         wdog_reg  <= 8'd0;
         tmo_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         rcnt_reg  <= rcnt_next;
         wdog_reg  <= wdog_next;
         tmo_reg   <= tmo_next;
      end
   end

`ifdef HAZARD_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_reg;
   logic [CNT_W-1:0] flush_cnt_reg;

   // Saturating counts of PC-stall cycles and ID/EX bubble cycles
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if (pc_stall_out && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         if (idex_flush_out && (flush_cnt_reg != '1))
            flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
   end

   assign stall_cnt_out = stall_cnt_reg;
   assign flush_cnt_out = flush_cnt_reg;
`else
   assign stall_cnt_out = '0;
   assign flush_cnt_out = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (REDIRECT_CYC=2, MC_MAX_CYC=8).
// Control vectors are packed as {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush}.
module tb_hazard_ctrl;

   logic        clk_in;
   logic        rst_in;
   logic [4:0]  id_rs1_in, id_rs2_in, ex_rd_in;
   logic        id_use_rs1_in, id_use_rs2_in;
   logic        ex_mem_read_in, ex_branch_taken_in, ex_mc_start_in, ex_mc_done_in;
   logic        pc_stall_out, ifid_stall_out, ifid_flush_out, idex_stall_out, idex_flush_out;
   logic [1:0]  state_out;
   logic        mc_timeout_out;
   logic [15:0] stall_cnt_out, flush_cnt_out;

   int n_cmp = 0;
   int n_err = 0;

   hazard_ctrl #(
      .INDEX(5), .REDIRECT_CYC(2), .MC_MAX_CYC(8), .CNT_W(16)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .id_rs1_in(id_rs1_in), .id_rs2_in(id_rs2_in),
      .id_use_rs1_in(id_use_rs1_in), .id_use_rs2_in(id_use_rs2_in),
      .ex_rd_in(ex_rd_in), .ex_mem_read_in(ex_mem_read_in),
      .ex_branch_taken_in(ex_branch_taken_in),
      .ex_mc_start_in(ex_mc_start_in), .ex_mc_done_in(ex_mc_done_in),
      .pc_stall_out(pc_stall_out), .ifid_stall_out(ifid_stall_out),
      .ifid_flush_out(ifid_flush_out), .idex_stall_out(idex_stall_out),
      .idex_flush_out(idex_flush_out), .state_out(state_out),
      .mc_timeout_out(mc_timeout_out),
      .stall_cnt_out(stall_cnt_out), .flush_cnt_out(flush_cnt_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] perf(input int v);
`ifdef HAZARD_CTRL_PERF_EN
      return 32'(v);
`else
      return 32'(v * 0);
`endif
   endfunction

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("check %-14s observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [4:0] ctl();
      return {pc_stall_out, ifid_stall_out, ifid_flush_out, idex_stall_out, idex_flush_out};
   endfunction

   // Wait for the falling edge, then check controls and registered state
   task automatic chk(input string tag, input logic [4:0] exp_ctl, input logic [1:0] exp_st);
      @(negedge clk_in);
      cmp({tag, "/ctl"}, 32'(ctl()), 32'(exp_ctl));
      cmp({tag, "/st"}, 32'(state_out), 32'(exp_st));
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs1_in = 5'd0; id_rs2_in = 5'd0; ex_rd_in = 5'd0;
      id_use_rs1_in = 1'b0; id_use_rs2_in = 1'b0;
      ex_mem_read_in = 1'b0; ex_branch_taken_in = 1'b0;
      ex_mc_start_in = 1'b0; ex_mc_done_in = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_in = 1'b0;
      tick();
      @(negedge clk_in);
      rst_in = 1'b1;
      tick();
   endtask

   initial begin
      idle_inputs();
      rst_in = 1'b0;
      #2;
      // Reset: controls forced low even with a branch request present
      ex_branch_taken_in = 1'b1;
      #3;
      cmp("rst/ctl", 32'(ctl()), 32'h0);
      cmp("rst/st", 32'(state_out), 32'h0);
      cmp("rst/tmo", 32'(mc_timeout_out), 32'h0);
      cmp("rst/scnt", 32'(stall_cnt_out), 32'h0);
      do_reset();

      // Load-use on rs1, then a second hazard on rs2 while in LOAD_STALL
      ex_mem_read_in = 1'b1; ex_rd_in = 5'd5; id_rs1_in = 5'd5; id_use_rs1_in = 1'b1;
      chk("lu0", 5'b11001, 2'd0);
      tick();
      id_use_rs1_in = 1'b0; id_rs1_in = 5'd0;
      ex_rd_in = 5'd7; id_rs2_in = 5'd7; id_use_rs2_in = 1'b1;
      chk("lu_again", 5'b11001, 2'd1);
      tick();
      idle_inputs();
      chk("lu_bubble", 5'b00000, 2'd1);
      tick();
      chk("lu_run", 5'b00000, 2'd0);
      // rd = x0 never hazards
      ex_mem_read_in = 1'b1; ex_rd_in = 5'd0; id_rs1_in = 5'd0; id_use_rs1_in = 1'b1;
      chk("lu_x0", 5'b00000, 2'd0);
      // Matching rs2 that the instruction does not read is no hazard
      ex_rd_in = 5'd9; id_rs2_in = 5'd9; id_use_rs1_in = 1'b0; id_use_rs2_in = 1'b0;
      chk("lu_nouse", 5'b00000, 2'd0);
      cmp("lu/scnt", 32'(stall_cnt_out), perf(2));
      cmp("lu/fcnt", 32'(flush_cnt_out), perf(2));
      do_reset();

      // Taken branch: 1 + 2 squashed fetch slots
      ex_branch_taken_in = 1'b1;
      chk("br0", 5'b00101, 2'd0);
      tick();
      idle_inputs();
      chk("br1", 5'b00100, 2'd3);
      tick();
      chk("br2", 5'b00100, 2'd3);
      tick();
      chk("br3", 5'b00000, 2'd0);
      cmp("br/fcnt", 32'(flush_cnt_out), perf(1));
      cmp("br/scnt", 32'(stall_cnt_out), perf(0));
      do_reset();

      // Multi-cycle op: start at cycle 0, done at cycle 5
      ex_mc_start_in = 1'b1;
      chk("mc0", 5'b11010, 2'd0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         // A branch during the hold must be ignored
         ex_branch_taken_in = (c == 2);
         chk($sformatf("mc%0d", c), 5'b11010, 2'd2);
      end
      tick();
      ex_branch_taken_in = 1'b0; ex_mc_done_in = 1'b1;
      chk("mc5", 5'b00000, 2'd2);
      tick();
      idle_inputs();
      chk("mc_end", 5'b00000, 2'd0);
      cmp("mc/scnt", 32'(stall_cnt_out), perf(5));
      do_reset();

      // Watchdog: done never arrives; 8 MC_WAIT stall cycles, then release
      ex_mc_start_in = 1'b1;
      chk("wd0", 5'b11010, 2'd0);
      for (int c = 1; c <= 8; c++) begin
         tick();
         chk($sformatf("wd%0d", c), 5'b11010, 2'd2);
      end
      tick();
      chk("wd_drop", 5'b00000, 2'd2);
      cmp("wd/tmo_pre", 32'(mc_timeout_out), 32'h0);
      tick();
      ex_mc_start_in = 1'b0;
      chk("wd_run", 5'b00000, 2'd0);
      cmp("wd/tmo", 32'(mc_timeout_out), 32'h1);
      tick();
      tick();
      cmp("wd/tmo_sticky", 32'(mc_timeout_out), 32'h1);
      cmp("wd/scnt", 32'(stall_cnt_out), perf(9));
      do_reset();
      cmp("wd/tmo_clr", 32'(mc_timeout_out), 32'h0);

      // Simultaneous branch, mc_start and load-use: redirect wins
      ex_branch_taken_in = 1'b1; ex_mc_start_in = 1'b1;
      ex_mem_read_in = 1'b1; ex_rd_in = 5'd3; id_rs1_in = 5'd3; id_use_rs1_in = 1'b1;
      chk("sim_all", 5'b00101, 2'd0);
      tick();
      idle_inputs();
      chk("sim_redir", 5'b00100, 2'd3);
      tick();
      tick();
      // mc_start with done in the same cycle: no stall, remain in RUN
      ex_mc_start_in = 1'b1; ex_mc_done_in = 1'b1;
      chk("sim_mcdone", 5'b00000, 2'd0);
      tick();
      idle_inputs();
      chk("sim_run", 5'b00000, 2'd0);
      cmp("sim/scnt", 32'(stall_cnt_out), perf(0));
      do_reset();

      // Reset mid-hold on MC_WAIT cycle 3 releases the pipe at once
      ex_mc_start_in = 1'b1;
      tick();
      tick();
      tick();
      @(negedge clk_in);
      cmp("mid/pre", 32'(ctl()), 32'h1a);
      rst_in = 1'b0;
      #1;
      cmp("mid/ctl", 32'(ctl()), 32'h0);
      cmp("mid/st", 32'(state_out), 32'h0);
      idle_inputs();
      tick();
      @(negedge clk_in);
      rst_in = 1'b1;
      tick();
      chk("mid_rel", 5'b00000, 2'd0);
      cmp("mid/scnt", 32'(stall_cnt_out), 32'h0);
      cmp("mid/fcnt", 32'(flush_cnt_out), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
